// File: rtl/mak8_run_controller.sv
// mak8_run_controller: turns board run/step/reset controls into a single-domain
// CPU clock enable, a stretched CPU reset and execution status.
module mak8_run_controller #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int PRESCALE_WIDTH    = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_mode,
  input  logic        step_btn,
  input  logic        soft_reset,
  input  logic [1:0]  speed_sel,
  input  logic        cpu_halted,
  output logic        cpu_ce,
  output logic        cpu_rst_n,
  output logic [1:0]  run_state,
  output logic [15:0] step_count,
  output logic        tick_led
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int PW = PRESCALE_WIDTH;

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_HALT  = 2'b01,
    S_RUN   = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    meta_q, meta_d, sync_q, sync_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_q, db_d, step_req_q, step_req_d;
  logic [PW-1:0] pre_q, pre_d, pre_mask;
  logic          tick_q, tick_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic [15:0]   step_count_q, step_count_d;
  logic          tick_led_q, tick_led_d;
  logic [4:0]    shift;
  logic          run_s, mode_s, btn_s, soft_s, db_hit;

  assign {soft_s, btn_s, mode_s, run_s} = sync_q;
  assign db_hit = db_cnt_q == DW'(DEBOUNCE_CYCLES - 1);
  assign shift = speed_sel == 2'b00 ? 5'd25 : speed_sel == 2'b01 ? 5'd20 : speed_sel == 2'b10 ? 5'd12 : 5'd0;
  assign pre_mask = PW'((64'd1 << shift) - 64'd1);
  // Step pulses ignore cpu_halted so a halted CPU can still be single-stepped.
  assign cpu_ce = (state_q == S_STEP) | ((state_q == S_RUN) & tick_q & ~cpu_halted);

  always_comb begin
    meta_d = {soft_reset, step_btn, step_mode, run_sw};
    sync_d = meta_q;
    db_cnt_d = (btn_s == db_q || db_hit) ? '0 : db_cnt_q + 1'b1;
    db_d = (btn_s != db_q && db_hit) ? btn_s : db_q;
    step_req_d = db_d & ~db_q;
    pre_d = pre_q + 1'b1;
    tick_d = (pre_q & pre_mask) == pre_mask;
    state_d = state_q;
    hold_d = hold_q;
    if (soft_s) begin
      state_d = S_RESET;
      hold_d = HW'(RESET_HOLD_CYCLES - 1);
    end else begin
      case (state_q)
        S_RESET: if (hold_q == '0) state_d = S_HALT; else hold_d = hold_q - 1'b1;
        S_HALT:  state_d = (mode_s & step_req_q) ? S_STEP : (~mode_s & run_s) ? S_RUN : S_HALT;
        S_RUN:   state_d = (~run_s | mode_s) ? S_HALT : S_RUN;
        default: state_d = S_HALT;
      endcase
    end
    cpu_rst_n_d = state_d != S_RESET;
    step_count_d = state_d == S_RESET ? '0 : step_count_q + {15'd0, cpu_ce};
    tick_led_d = state_d == S_RESET ? 1'b0 : tick_led_q ^ cpu_ce;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RESET;
      hold_q       <= HW'(RESET_HOLD_CYCLES - 1);
      meta_q       <= '0;
      sync_q       <= '0;
      db_cnt_q     <= '0;
      db_q         <= 1'b0;
      step_req_q   <= 1'b0;
      pre_q        <= '0;
      tick_q       <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      step_count_q <= '0;
      tick_led_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      db_cnt_q     <= db_cnt_d;
      db_q         <= db_d;
      step_req_q   <= step_req_d;
      pre_q        <= pre_d;
      tick_q       <= tick_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      step_count_q <= step_count_d;
      tick_led_q   <= tick_led_d;
    end
  end

  assign cpu_rst_n  = cpu_rst_n_q;
  assign run_state  = state_q;
  assign step_count = step_count_q;
  assign tick_led   = tick_led_q;
endmodule
